// File: rtl/qosc_multi.sv
// qosc_multi: N-channel quadrature oscillator, time-multiplexed onto one signed WxW multiplier.
// Define QOSC_AGC_EN to add the magnitude/correction stages that pull re^2+im^2 toward power.
module qosc_multi #(
  parameter int W         = 16,
  parameter int CHANNELS  = 4,
  parameter int AGC_SHIFT = 8,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [W-1:0]  power,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_chan,
  input  logic [1:0]    cfg_addr,
  input  logic [W-1:0]  cfg_data,
  output logic          out_valid,
  output logic [CW-1:0] out_chan,
  output logic [W-1:0]  out_re,
  output logic [W-1:0]  out_im,
  output logic          busy,
  output logic          overrun
);
  localparam int PW = 2 * W;
  localparam int XW = 2 * W + 2;
  localparam logic signed [XW-1:0] SAT_MAX  = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN  = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [XW-1:0] RND_BIAS = {{(XW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_ROT0, S_ROT1, S_ROT2, S_ROT3,
`ifdef QOSC_AGC_EN
    S_MAG0, S_MAG1, S_COR0, S_COR1,
`endif
    S_WB
  } state_t;

  function automatic logic signed [W-1:0] sat_w(input logic signed [XW-1:0] x);
    logic signed [W-1:0] y;
    if (x > SAT_MAX) y = SAT_MAX[W-1:0];
    else if (x < SAT_MIN) y = SAT_MIN[W-1:0];
    else y = x[W-1:0];
    return y;
  endfunction

  // Round-half-up a Q2.(2W-2) product back to Q1.(W-1), kept wide for the following add.
  function automatic logic signed [XW-1:0] rnd(input logic signed [PW-1:0] p);
    logic signed [XW-1:0] t;
    t = XW'(p) + RND_BIAS;
    return t >>> (W - 1);
  endfunction

  state_t              state_r;
  logic [CW-1:0]       ch_r;
  logic                pend_r;
  logic                overrun_r;
  logic signed [W-1:0] st_re_r [CHANNELS];
  logic signed [W-1:0] st_im_r [CHANNELS];
  logic signed [W-1:0] co_re_r [CHANNELS];
  logic signed [W-1:0] co_im_r [CHANNELS];
  logic signed [XW-1:0] acc_r;
  logic signed [W-1:0] nre_r;
  logic signed [W-1:0] nim_r;
  logic                out_valid_r;
  logic [CW-1:0]       out_chan_r;
  logic [W-1:0]        out_re_r;
  logic [W-1:0]        out_im_r;
`ifdef QOSC_AGC_EN
  logic [PW-1:0]       mag_r;
  logic signed [W-1:0] err_r;
`else
  logic                unused_s;
  assign unused_s = ^power;
`endif

  logic signed [W-1:0]  mul_a_s;
  logic signed [W-1:0]  mul_b_s;
  logic signed [PW-1:0] prod_s;
  logic                 last_s;
  logic                 cfg_hit_s;

  assign last_s    = (ch_r == CW'(CHANNELS - 1));
  assign cfg_hit_s = cfg_valid && (state_r == S_IDLE) &&
                     ({1'b0, cfg_chan} < (CW+1)'(CHANNELS));

  // Operand select for the single shared multiplier: one product per FSM cycle.
  always_comb begin
    mul_a_s = {W{1'b0}};
    mul_b_s = {W{1'b0}};
    case (state_r)
      S_ROT0: begin mul_a_s = st_re_r[ch_r]; mul_b_s = co_re_r[ch_r]; end
      S_ROT1: begin mul_a_s = st_im_r[ch_r]; mul_b_s = co_im_r[ch_r]; end
      S_ROT2: begin mul_a_s = st_re_r[ch_r]; mul_b_s = co_im_r[ch_r]; end
      S_ROT3: begin mul_a_s = st_im_r[ch_r]; mul_b_s = co_re_r[ch_r]; end
`ifdef QOSC_AGC_EN
      S_MAG0: begin mul_a_s = nre_r; mul_b_s = nre_r; end
      S_MAG1: begin mul_a_s = nim_r; mul_b_s = nim_r; end
      S_COR0: begin mul_a_s = nre_r; mul_b_s = err_r; end
      S_COR1: begin mul_a_s = nim_r; mul_b_s = err_r; end
`endif
      default: begin mul_a_s = {W{1'b0}}; mul_b_s = {W{1'b0}}; end
    endcase
  end

  assign prod_s = PW'(mul_a_s) * PW'(mul_b_s);

  // Sequencer, datapath accumulators, per-channel storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ch_r        <= {CW{1'b0}};
      pend_r      <= 1'b0;
      overrun_r   <= 1'b0;
      acc_r       <= {XW{1'b0}};
      nre_r       <= {W{1'b0}};
      nim_r       <= {W{1'b0}};
      out_valid_r <= 1'b0;
      out_chan_r  <= {CW{1'b0}};
      out_re_r    <= {W{1'b0}};
      out_im_r    <= {W{1'b0}};
`ifdef QOSC_AGC_EN
      mag_r       <= {PW{1'b0}};
      err_r       <= {W{1'b0}};
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        st_re_r[i] <= {W{1'b0}};
        st_im_r[i] <= {W{1'b0}};
        co_re_r[i] <= {W{1'b0}};
        co_im_r[i] <= {W{1'b0}};
      end
    end else begin
      out_valid_r <= 1'b0;
      if (cfg_hit_s) begin
        case (cfg_addr)
          2'd0:    co_re_r[cfg_chan] <= cfg_data;
          2'd1:    co_im_r[cfg_chan] <= cfg_data;
          2'd2:    st_re_r[cfg_chan] <= cfg_data;
          2'd3:    st_im_r[cfg_chan] <= cfg_data;
          default: ;
        endcase
      end
      // A step during a sweep queues one more sweep; a second one is lost and flagged.
      if (step && (state_r != S_IDLE)) begin
        if (pend_r) overrun_r <= 1'b1;
        else pend_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (step) begin
            ch_r    <= {CW{1'b0}};
            state_r <= S_ROT0;
          end
        end
        S_ROT0: begin acc_r <= rnd(prod_s); state_r <= S_ROT1; end
        S_ROT1: begin nre_r <= sat_w(acc_r - rnd(prod_s)); state_r <= S_ROT2; end
        S_ROT2: begin acc_r <= rnd(prod_s); state_r <= S_ROT3; end
        S_ROT3: begin
          nim_r <= sat_w(acc_r + rnd(prod_s));
`ifdef QOSC_AGC_EN
          state_r <= S_MAG0;
`else
          state_r <= S_WB;
`endif
        end
`ifdef QOSC_AGC_EN
        S_MAG0: begin mag_r <= prod_s; state_r <= S_MAG1; end
        S_MAG1: begin
          err_r   <= sat_w($signed({{(XW-W){1'b0}}, power}) - $signed({2'b00, mag_r}) - XW'(prod_s));
          state_r <= S_COR0;
        end
        S_COR0: begin nre_r <= sat_w(XW'(nre_r) + XW'(prod_s >>> AGC_SHIFT)); state_r <= S_COR1; end
        S_COR1: begin nim_r <= sat_w(XW'(nim_r) + XW'(prod_s >>> AGC_SHIFT)); state_r <= S_WB; end
`endif
        S_WB: begin
          st_re_r[ch_r] <= nre_r;
          st_im_r[ch_r] <= nim_r;
          out_valid_r   <= 1'b1;
          out_chan_r    <= ch_r;
          out_re_r      <= nre_r;
          out_im_r      <= nim_r;
          if (!last_s) begin
            ch_r    <= ch_r + CW'(1);
            state_r <= S_ROT0;
          end else if (pend_r || step) begin
            ch_r    <= {CW{1'b0}};
            pend_r  <= 1'b0;
            state_r <= S_ROT0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_r == S_IDLE);
  assign busy      = (state_r != S_IDLE);
  assign overrun   = overrun_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;
  assign out_re    = out_re_r;
  assign out_im    = out_im_r;

endmodule

// File: tb/tb_qosc_multi.sv
// Bench for qosc_multi: directed scenarios and randomized sweeps compared against an
// arithmetic reference model of the rotation (and AGC when QOSC_AGC_EN is defined).
`timescale 1ns/1ps
module tb_qosc_multi;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int CW = 2;
`ifdef QOSC_AGC_EN
  localparam int P       = 9;
  localparam int EXP2_RE = 32;
  localparam int EXP4_IM = -32768;
`else
  localparam int P       = 5;
  localparam int EXP2_RE = 31;
  localparam int EXP4_IM = 32767;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          step;
  logic [W-1:0]  power;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [1:0]    cfg_addr;
  logic [W-1:0]  cfg_data;
  logic          out_valid;
  logic [CW-1:0] out_chan;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic          busy;
  logic          overrun;

  qosc_multi #(.W(W), .CHANNELS(CH), .AGC_SHIFT(8)) dut (
    .clk(clk), .rst(rst), .step(step), .power(power),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_chan(out_chan), .out_re(out_re), .out_im(out_im),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int m_re[CH], m_im[CH], m_cr[CH], m_ci[CH];
  int m_pow;
  int obs_re[CH], obs_im[CH];

  function automatic int sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  function automatic longint rnd(input longint p);
    return (p + 64'sd16384) >>> 15;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Reference: one oscillator step of channel k, straight from the arithmetic rules.
  function automatic void model_step(input int k);
    longint re, im, cr, ci;
    int nre, nim;
`ifdef QOSC_AGC_EN
    longint mag;
    int err;
`endif
    re = m_re[k]; im = m_im[k]; cr = m_cr[k]; ci = m_ci[k];
    nre = sat16(rnd(re * cr) - rnd(im * ci));
    nim = sat16(rnd(re * ci) + rnd(im * cr));
`ifdef QOSC_AGC_EN
    mag = longint'(nre) * nre + longint'(nim) * nim;
    err = sat16(longint'(m_pow) - mag);
    nre = sat16(longint'(nre) + ((longint'(nre) * err) >>> 8));
    nim = sat16(longint'(nim) + ((longint'(nim) * err) >>> 8));
`endif
    m_re[k] = nre;
    m_im[k] = nim;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_cfg(input int ch, input int addr, input int data);
    int v;
    v = int'($signed(16'(data)));
    if (ch < CH) begin
      case (addr)
        0: m_cr[ch] = v;
        1: m_ci[ch] = v;
        2: m_re[ch] = v;
        default: m_im[ch] = v;
      endcase
    end
  endfunction

  task automatic cfg_wr(input int ch, input int addr, input int data);
    cfg_valid = 1'b1; cfg_chan = CW'(ch); cfg_addr = 2'(addr); cfg_data = 16'(data);
    @(negedge clk);
    cfg_valid = 1'b0;
    model_cfg(ch, addr, data);
  endtask

  task automatic pulse_step(output int t0);
    t0 = cyc; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Collect n back-to-back output pulses of a sweep that started at cycle t0.
  task automatic expect_pulses(input int n, input int t0);
    for (int i = 0; i < n; i++) begin
      int k;
      int budget;
      k = i % CH;
      budget = 2 * P + 4;
      while (out_valid !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("pulse_seen", out_valid, 1);
      if (out_valid !== 1'b1) return;
      chk("pulse_time", cyc, t0 + 1 + (i + 1) * P);
      chk("pulse_chan", out_chan, k);
      model_step(k);
      chk("pulse_re", s16(out_re), m_re[k]);
      chk("pulse_im", s16(out_im), m_im[k]);
      obs_re[k] = s16(out_re);
      obs_im[k] = s16(out_im);
      @(negedge clk);
      chk("pulse_width", out_valid, 0);
    end
  endtask

  task automatic count_quiet(input int cycles, input string tag);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1; step = 1'b0; power = '0; cfg_valid = 1'b0;
    cfg_chan = '0; cfg_addr = '0; cfg_data = '0;
    m_pow = 0;
    for (int i = 0; i < CH; i++) begin
      m_re[i] = 0; m_im[i] = 0; m_cr[i] = 0; m_ci[i] = 0; obs_re[i] = 0; obs_im[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_overrun", overrun, 0);

    // Known rotation vector on ch0, plus ch1 guarded against a write attempted mid-sweep.
    power = 16'h0400; m_pow = 'h400;
    cfg_wr(0, 0, 'h7d34); cfg_wr(0, 1, 'h1a9d); cfg_wr(0, 2, 'h0020); cfg_wr(0, 3, 0);
    cfg_wr(1, 0, 'h4000); cfg_wr(1, 1, 0); cfg_wr(1, 2, 'h0100); cfg_wr(1, 3, 'h0200);
    pulse_step(t0);
    chk("sweep_busy", busy, 1);
    chk("sweep_ready_low", cfg_ready, 0);
    cfg_valid = 1'b1; cfg_chan = CW'(5); cfg_addr = 2'd2; cfg_data = 16'h5555;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("sweep_ready_low2", cfg_ready, 0);
    expect_pulses(CH, t0);
    chk("vec_re", obs_re[0], EXP2_RE);
    chk("vec_im", obs_im[0], 7);

    // Saturation corner on ch2, and a cfg write sharing the IDLE cycle with step on ch3.
    power = 16'h0000; m_pow = 0;
    cfg_wr(2, 0, 'h7fff); cfg_wr(2, 1, 'h7fff); cfg_wr(2, 2, 'h7fff); cfg_wr(2, 3, 'h7fff);
    cfg_wr(3, 0, 'h7fff); cfg_wr(3, 1, 0);
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_addr = 2'd2; cfg_data = 16'h1234;
    t0 = cyc; step = 1'b1;
    @(negedge clk);
    step = 1'b0; cfg_valid = 1'b0;
    model_cfg(3, 2, 'h1234);
    expect_pulses(CH, t0);
    chk("sat_re", obs_re[2], 0);
    chk("sat_im", obs_im[2], EXP4_IM);

    // Randomized configurations, each run for two sweeps; ch (r%CH) gets a zero coefficient.
    for (int r = 0; r < 6; r++) begin
      int pw;
      pw = int'($urandom_range(0, 65535));
      power = 16'(pw); m_pow = pw;
      for (int k = 0; k < CH; k++) begin
        if (k == r % CH) begin
          cfg_wr(k, 0, 0); cfg_wr(k, 1, 0);
        end else begin
          cfg_wr(k, 0, int'($urandom_range(0, 65535)));
          cfg_wr(k, 1, int'($urandom_range(0, 65535)));
        end
        cfg_wr(k, 2, int'($urandom_range(0, 65535)));
        cfg_wr(k, 3, int'($urandom_range(0, 65535)));
      end
      pulse_step(t0);
      expect_pulses(CH, t0);
      chk("zero_coeff_re", obs_re[r % CH], 0);
      chk("zero_coeff_im", obs_im[r % CH], 0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      pulse_step(t0);
      expect_pulses(CH, t0);
    end

    // Three consecutive steps: one sweep, one queued, one dropped with overrun.
    chk("pre_overrun", overrun, 0);
    t0 = cyc; step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    chk("overrun_set", overrun, 1);
    expect_pulses(2 * CH, t0);
    count_quiet(3 * P, "no_third_sweep");
    chk("idle_after_two", busy, 0);

    // Reset held three cycles mid-sweep aborts everything.
    pulse_step(t0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_re[i] = 0; m_im[i] = 0; m_cr[i] = 0; m_ci[i] = 0;
    end
    @(negedge clk);
    chk("mid_rst_out_re", out_re, 0);
    chk("mid_rst_out_im", out_im, 0);
    chk("mid_rst_out_chan", out_chan, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cfg_ready, 1);
    chk("mid_rst_overrun", overrun, 0);
    count_quiet(4 * CH * P, "mid_rst_quiet");

    // Fresh sweep after reset runs from the cleared state.
    cfg_wr(1, 0, 'h7fff); cfg_wr(1, 2, 'h0400);
    pulse_step(t0);
    expect_pulses(CH, t0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
